if_fetch: RTL

- Instruction-fetch stage that directly feeds the IF/ID pipeline register.
- Owns the PC, issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake, and buffers one fetched instruction.
- Honours the hazard-unit stop (hold) and the EX-stage branch/jump redirect (flush).
- Presents if_valid/if_pc/if_inst, held stable while stop is high, matching the IF/ID register's hold behaviour.

---
 rtl/if_fetch_pkg.sv | 15 +
 rtl/if_fetch_out_buf.sv | 44 ++++
 rtl/if_fetch.sv | 96 +++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INST      : encoding loaded into the IF/ID instruction slot on reset
//   PC_STEP       : byte increment between sequential fetches
//   fetch_state_e : fetch FSM encoding (REQ may request, WAIT has one outstanding)
package if_fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic {
        FETCH_REQ  = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_out_buf.sv
// One-entry output buffer feeding the IF/ID pipeline register.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : redirect from EX; drops the buffered instruction
//   hold          : downstream stop; buffered instruction is neither consumed nor changed
//   capture       : live instruction returned by memory this cycle
//   capture_pc    : PC of the captured instruction
//   capture_inst  : captured instruction word
//   valid/pc/inst : registered buffer contents
module if_out_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic        capture,
    input  logic [31:0] capture_pc,
    input  logic [31:0] capture_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    // Priority: flush > capture > consume. A capture never meets a held
    // live entry, because no request is issued while valid && hold.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            valid <= 1'b0;
            pc    <= 32'h0000_0000;
            inst  <= NOP_INST;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            pc    <= capture_pc;
            inst  <= capture_inst;
        end else if (valid && !hold) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps a single request outstanding
// to instruction memory (req/gnt/rvalid) and buffers one fetched instruction
// for the IF/ID register.
//   clk, rst       : clock, synchronous active-high reset
//   stop           : downstream hold of the output buffer
//   redirect       : taken branch/jump from EX; redirect_pc is the new target
//   imem_req/addr  : memory request and address (combinational from state/pc)
//   imem_gnt       : request accepted this cycle
//   imem_rvalid    : read data valid, imem_rdata the instruction word
//   if_valid/pc/inst : registered instruction presented to IF/ID
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = if_fetch_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);
    import if_fetch_pkg::*;

    fetch_state_e state;
    logic         kill;      // outstanding response must be discarded
    logic [31:0]  pc;
    logic [31:0]  req_pc;    // PC of the request currently outstanding

    logic slot_free;
    logic grant;
    logic capture;
    logic outstanding_next;

    assign slot_free = !if_valid || !stop;
    assign imem_req  = !rst && (state == FETCH_REQ) && slot_free && !redirect;
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;
    assign capture   = (state == FETCH_WAIT) && imem_rvalid && !kill;

    // A response is still owed to us after this edge if we were waiting and
    // it did not arrive, a stale one (kill in REQ, left by a reset) has not
    // arrived yet, or a new grant just happened.
    assign outstanding_next = (((state == FETCH_WAIT) || kill) && !imem_rvalid) || grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH_REQ;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            // A response still in flight across reset is stale.
            kill   <= ((state == FETCH_WAIT) || kill) && !imem_rvalid;
        end else begin
            unique case (state)
                FETCH_REQ: begin
                    if (grant) begin
                        state  <= FETCH_WAIT;
                        req_pc <= pc;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) state <= FETCH_REQ;
                end
                default: state <= FETCH_REQ;
            endcase

            // A stale response arriving in REQ only clears kill; its data
            // is never captured.
            if (redirect) kill <= outstanding_next;
            else          kill <= kill && !imem_rvalid;

            if (redirect)   pc <= redirect_pc;
            else if (grant) pc <= pc + PC_STEP;
        end
    end

    if_out_buf u_out_buf (
        .clk          (clk),
        .rst          (rst),
        .flush        (redirect),
        .hold         (stop),
        .capture      (capture),
        .capture_pc   (req_pc),
        .capture_inst (imem_rdata),
        .valid        (if_valid),
        .pc           (if_pc),
        .inst         (if_inst)
    );

endmodule
